vc_sram_port_ctrl: RTL and testbench
====================================

Name: vc_sram_port_ctrl

Overview:
Initiator-side controller for the team's 1rw synchronous SRAM model (1-cycle registered read, per-byte write enables, read and write never enabled together). Turns a val/rdy memory request stream into legal SRAM port activity and returns an in-order val/rdy response stream. A 2-entry response queue absorbs backpressure. An optional clear FSM writes zeros to every entry after reset.

Parameters:
p_data_nbits, 32, SRAM word width.
p_num_entries, 256, SRAM depth.
p_clear_on_reset, 1, 1 = zero-fill all entries after reset before accepting requests.
c_addr_nbits, $clog2(p_num_entries), local; not set from outside.
c_data_nbytes, (p_data_nbits+7)/8, local; not set from outside.

Ports:
clk  in  1  single clock; all state on the rising edge.
reset  in  1  asynchronous, active-low (asserted at 0).
req_val / req_rdy  in / out  1 / 1  request handshake.
req_type  in  1  0 = read, 1 = write.
req_addr  in  c_addr_nbits  word address.
req_byte_en  in  c_data_nbytes  write byte mask; ignored for reads.
req_data  in  p_data_nbits  write data.
resp_val / resp_rdy  out / in  1 / 1  response handshake.
resp_type  out  1  echoes req_type.
resp_data  out  p_data_nbits  read data; 0 for writes.
sram_read_en, sram_write_en  out  1 each  SRAM enables.
sram_read_addr, sram_write_addr  out  c_addr_nbits each  SRAM addresses.
sram_write_byte_en  out  c_data_nbytes  SRAM byte enables.
sram_write_data  out  p_data_nbits  SRAM write data.
sram_read_data  in  p_data_nbits  SRAM read data, valid the cycle after sram_read_en.
init_done  out  1  high once the clear is complete (or immediately if p_clear_on_reset = 0).

Behaviour:
- Reset (reset = 0, asynchronous): state = INIT if p_clear_on_reset, else READY; clear counter = 0; s1_val = 0; queue empty.
  Outputs while reset is held: req_rdy = 0, resp_val = 0, init_done = 0, sram_read_en = 0, sram_write_en = 0.
  Reset asserted mid-clear or mid-transaction discards all in-flight work; the clear restarts at address 0.
- INIT state:
  - Each cycle: sram_write_en = 1, sram_write_byte_en = all 1s, sram_write_data = 0, sram_write_addr = counter; counter increments.
  - req_rdy = 0 throughout.
  - Transition: after writing address p_num_entries-1, go to READY. init_done rises the following cycle.
  - Clear takes exactly p_num_entries cycles.
- READY state:
  - fire = req_val & req_rdy.
  - On fire, the SRAM is driven combinationally in the same cycle:
    - read: sram_read_en = 1, sram_read_addr = req_addr.
    - write: sram_write_en = 1 with req_addr, req_byte_en, req_data.
  - With no fire, both enables are 0. Read and write enables are never both 1.
- Stage 1 (registered on fire): s1_val, s1_type.
  - For reads, the result is sram_read_data in that next cycle. sram_read_data is never sampled unless s1_val & read.
  - For writes, the result data is 0.
- Response path:
  - Queue empty and s1_val: bypass. resp_val = 1 and resp_* come from s1. If resp_rdy = 0, the s1 result is enqueued.
  - Queue non-empty: the response comes from the queue head; the s1 result is enqueued behind it.
  - Responses are strictly in request order.
- Flow control: req_rdy = (state == READY) & (count + s1_val < 2). The queue never overflows, and there are no combinational paths from resp_rdy to req_rdy.
- Latency and throughput: minimum 1 cycle from fire to resp_val. Throughput is 1 request/cycle while resp_rdy stays high.
- Assertions (when reset = 1): req_val and resp_rdy are not X; on fire, req_addr < p_num_entries and is not X.

Decomposition:
- Shared package vc_sram_ctrl_pkg holds:
  - req type constants c_req_rd = 0, c_req_wr = 1;
  - FSM encoding c_state_init = 0, c_state_ready = 1.
- One sub-module: vc_sram_resp_queue, a 2-entry in-order queue with enq/deq val/rdy and a count output.
- The top level holds the FSM, clear counter, stage-1 register and bypass mux.

Test Plan:
1. Clear: p_num_entries = 8, reset released → exactly 8 zero writes to addresses 0..7. req_rdy = 0 until after address 7, then init_done = 1. A read of address 5 returns 0.
2. Byte-enable write: write addr 3, data 0xDEADBEEF, byte_en 4'b0011, then read addr 3 → resp_type = 1, data 0; then resp_type = 0, data 0x0000BEEF.
3. Back-to-back: with resp_rdy = 1, alternate write/read to addresses 0..3 every cycle → one response per cycle, in order, latency 1, sram_read_en and sram_write_en never both 1.
4. Backpressure: hold resp_rdy = 0 and stream reads → req_rdy drops after 2 accepts. On release, 2 queued responses drain in order, then streaming resumes with no loss.
5. Reset mid-operation: assert reset during the clear at counter = 4 and again with 2 responses queued → resp_val = 0 immediately. The clear restarts at address 0 and no stale responses appear afterwards.
6. p_clear_on_reset = 0: reset released → init_done = 1 and req_rdy = 1 in the first cycle, with no SRAM writes issued.

Source files
------------

// File: rtl/vc_sram_port_ctrl_pkg.sv
// Shared constants for the SRAM port controller: request type codes and FSM encoding.
// No logic; imported by the controller top.
package vc_sram_ctrl_pkg;

   localparam logic c_req_rd = 1'b0;
   localparam logic c_req_wr = 1'b1;

   typedef enum logic {
      c_state_init  = 1'b0,
      c_state_ready = 1'b1
   } state_t;

endpackage

// File: rtl/vc_sram_port_ctrl_if.sv
// Request/response val/rdy bundle between an initiator (master) and the SRAM port controller (slave).
// Widths follow the SRAM word width and depth.
interface vc_sram_port_ctrl_if #(
   parameter int p_data_nbits  = 32,
   parameter int p_num_entries = 256
);
   localparam int c_addr_nbits  = $clog2(p_num_entries);
   localparam int c_data_nbytes = (p_data_nbits + 7) / 8;

   logic                     req_val;
   logic                     req_rdy;
   logic                     req_type;
   logic [c_addr_nbits-1:0]  req_addr;
   logic [c_data_nbytes-1:0] req_byte_en;
   logic [p_data_nbits-1:0]  req_data;

   logic                     resp_val;
   logic                     resp_rdy;
   logic                     resp_type;
   logic [p_data_nbits-1:0]  resp_data;

   modport master (
      output req_val, req_type, req_addr, req_byte_en, req_data, resp_rdy,
      input  req_rdy, resp_val, resp_type, resp_data
   );

   modport slave (
      input  req_val, req_type, req_addr, req_byte_en, req_data, resp_rdy,
      output req_rdy, resp_val, resp_type, resp_data
   );

endinterface

// File: rtl/vc_sram_port_ctrl_resp_queue.sv
// 2-entry in-order response queue; enq visible at deq the cycle after it is written.
// enq_rdy drops when full; count is registered so it never depends on deq_rdy.
module vc_sram_resp_queue #(
   parameter int p_nbits = 33
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_enq_val,
   output logic               o_enq_rdy,
   input  logic [p_nbits-1:0] i_enq_data,
   output logic               o_deq_val,
   input  logic               i_deq_rdy,
   output logic [p_nbits-1:0] o_deq_data,
   output logic [1:0]         o_count
);

   logic [p_nbits-1:0] r_entry [2];
   logic               r_wr_ptr;
   logic               r_rd_ptr;
   logic [1:0]         r_count;
   logic               w_enq;
   logic               w_deq;

   assign o_enq_rdy  = (r_count != 2'd2);
   assign o_deq_val  = (r_count != 2'd0);
   assign w_enq      = i_enq_val & o_enq_rdy;
   assign w_deq      = o_deq_val & i_deq_rdy;
   assign o_deq_data = r_entry[r_rd_ptr];
   assign o_count    = r_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_enq) r_wr_ptr <= ~r_wr_ptr;
         if (w_deq) r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
      end
   end

   // Payload storage needs no reset: it is only read while count is non-zero.
   always_ff @(posedge clk) begin
      if (w_enq) r_entry[r_wr_ptr] <= i_enq_data;
   end

endmodule

// File: rtl/vc_sram_port_ctrl.sv
// Drives a 1rw SRAM from a val/rdy request stream and returns in-order responses, with optional zero-fill.
// Response 1 cycle after fire; 2-entry queue absorbs resp_rdy stalls, req_rdy depends only on registers.
module vc_sram_port_ctrl
   import vc_sram_ctrl_pkg::*;
#(
   parameter int p_data_nbits     = 32,
   parameter int p_num_entries    = 256,
   parameter bit p_clear_on_reset = 1'b1,
   localparam int c_addr_nbits    = $clog2(p_num_entries),
   localparam int c_data_nbytes   = (p_data_nbits + 7) / 8
) (
   input  logic                     clk,
   input  logic                     reset,
   vc_sram_port_ctrl_if.slave       mem,
   output logic                     sram_read_en,
   output logic                     sram_write_en,
   output logic [c_addr_nbits-1:0]  sram_read_addr,
   output logic [c_addr_nbits-1:0]  sram_write_addr,
   output logic [c_data_nbytes-1:0] sram_write_byte_en,
   output logic [p_data_nbits-1:0]  sram_write_data,
   input  logic [p_data_nbits-1:0]  sram_read_data,
   output logic                     init_done
);

   localparam logic [c_addr_nbits-1:0] c_last_addr = c_addr_nbits'(p_num_entries - 1);

   state_t                  r_state;
   logic [c_addr_nbits-1:0] r_clr_cnt;
   logic                    r_s1_val;
   logic                    r_s1_type;

   logic                    w_clearing;
   logic                    w_ready;
   logic                    w_fire;
   logic [p_data_nbits-1:0] w_s1_data;
   logic                    w_q_enq_val;
   logic                    w_q_enq_rdy;
   logic                    w_q_val;
   logic [p_data_nbits:0]   w_q_data;
   logic [1:0]              w_q_count;

   // Gating with reset keeps every handshake and enable low while reset is held.
   assign w_clearing  = reset & (r_state == c_state_init);
   assign w_ready     = reset & (r_state == c_state_ready);
   assign init_done   = w_ready;
   assign mem.req_rdy = w_ready & ((w_q_count + {1'b0, r_s1_val}) < 2'd2);
   assign w_fire      = mem.req_val & mem.req_rdy;

   assign sram_read_en       = w_fire & (mem.req_type == c_req_rd);
   assign sram_read_addr     = mem.req_addr;
   assign sram_write_en      = w_clearing | (w_fire & (mem.req_type == c_req_wr));
   assign sram_write_addr    = w_clearing ? r_clr_cnt : mem.req_addr;
   assign sram_write_byte_en = w_clearing ? {c_data_nbytes{1'b1}} : mem.req_byte_en;
   assign sram_write_data    = w_clearing ? {p_data_nbits{1'b0}} : mem.req_data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         if (p_clear_on_reset) r_state <= c_state_init;
         else                  r_state <= c_state_ready;
         r_clr_cnt <= '0;
         r_s1_val  <= 1'b0;
         r_s1_type <= c_req_rd;
      end else begin
         r_s1_val <= w_fire;
         if (w_fire) r_s1_type <= mem.req_type;
         if (r_state == c_state_init) begin
            r_clr_cnt <= r_clr_cnt + c_addr_nbits'(1);
            if (r_clr_cnt == c_last_addr) r_state <= c_state_ready;
         end
      end
   end

   assign w_s1_data = (r_s1_val && (r_s1_type == c_req_rd)) ? sram_read_data : '0;

   // s1 bypasses straight to the output only when nothing older is queued and it is taken now.
   assign w_q_enq_val = r_s1_val & ~(~w_q_val & mem.resp_rdy);

   vc_sram_resp_queue #(
      .p_nbits (p_data_nbits + 1)
   ) u_resp_queue (
      .clk        (clk),
      .reset      (reset),
      .i_enq_val  (w_q_enq_val),
      .o_enq_rdy  (w_q_enq_rdy),
      .i_enq_data ({r_s1_type, w_s1_data}),
      .o_deq_val  (w_q_val),
      .i_deq_rdy  (mem.resp_rdy),
      .o_deq_data (w_q_data),
      .o_count    (w_q_count)
   );

   assign mem.resp_val  = w_q_val | r_s1_val;
   assign mem.resp_type = w_q_val ? w_q_data[p_data_nbits] : r_s1_type;
   assign mem.resp_data = w_q_val ? w_q_data[p_data_nbits-1:0] : w_s1_data;

   a_ctrl_known: assert property (@(posedge clk) disable iff (!reset)
      !$isunknown({mem.req_val, mem.resp_rdy}));
   a_addr_legal: assert property (@(posedge clk) disable iff (!reset)
      w_fire |-> (!$isunknown(mem.req_addr) && (int'(mem.req_addr) < p_num_entries)));
   a_queue_room: assert property (@(posedge clk) disable iff (!reset)
      w_q_enq_val |-> w_q_enq_rdy);
   a_rw_excl: assert property (@(posedge clk) disable iff (!reset)
      !(sram_read_en && sram_write_en));

endmodule

// File: tb/tb_vc_sram_port_ctrl.sv
// Bench for vc_sram_port_ctrl: directed clear/byte-enable/backpressure/reset cases plus random traffic,
// scored against a byte-array memory and an expected-response queue.
module tb_vc_sram_port_ctrl;

   localparam int c_n = 8;

   typedef struct packed {
      logic        typ;
      logic [31:0] data;
      int          cyc;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   vc_sram_port_ctrl_if #(.p_data_nbits(32), .p_num_entries(c_n)) mem_if   ();
   vc_sram_port_ctrl_if #(.p_data_nbits(32), .p_num_entries(c_n)) mem_if_b ();

   logic        sram_re, sram_we, init_done;
   logic [2:0]  sram_raddr, sram_waddr;
   logic [3:0]  sram_be;
   logic [31:0] sram_wd, sram_rd;
   logic        b_re, b_we, b_init_done;
   logic [2:0]  b_raddr, b_waddr;
   logic [3:0]  b_be;
   logic [31:0] b_wd;

   vc_sram_port_ctrl #(.p_data_nbits(32), .p_num_entries(c_n), .p_clear_on_reset(1'b1)) u_dut (
      .clk(clk), .reset(rst_n), .mem(mem_if),
      .sram_read_en(sram_re), .sram_write_en(sram_we),
      .sram_read_addr(sram_raddr), .sram_write_addr(sram_waddr),
      .sram_write_byte_en(sram_be), .sram_write_data(sram_wd),
      .sram_read_data(sram_rd), .init_done(init_done));

   vc_sram_port_ctrl #(.p_data_nbits(32), .p_num_entries(c_n), .p_clear_on_reset(1'b0)) u_dut_nc (
      .clk(clk), .reset(rst_n), .mem(mem_if_b),
      .sram_read_en(b_re), .sram_write_en(b_we),
      .sram_read_addr(b_raddr), .sram_write_addr(b_waddr),
      .sram_write_byte_en(b_be), .sram_write_data(b_wd),
      .sram_read_data(32'h0), .init_done(b_init_done));

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   b_en_cnt = 0;
   bit   rand_mode;
   bit   chk_lat;
   ent_t exp_q[$];
   ent_t obs_q[$];
   ent_t mon_e;
   logic [31:0] ref_mem [c_n];
   logic [31:0] sram_arr [c_n];

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
      end
   endtask

   // 1rw SRAM with registered read; reset fills it with junk so only the clear can zero it.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < c_n; i++) sram_arr[i] <= 32'hA5A5_0000 | 32'(i);
      end else begin
         if (sram_re) sram_rd <= sram_arr[sram_raddr];
         if (sram_we)
            for (int b = 0; b < 4; b++)
               if (sram_be[b]) sram_arr[sram_waddr][8*b +: 8] <= sram_wd[8*b +: 8];
      end
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      if (b_we | b_re) b_en_cnt++;
   end

   // Reference: every accepted request yields one response, in order; reads see all earlier writes.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         exp_q.delete();
         obs_q.delete();
         for (int i = 0; i < c_n; i++) ref_mem[i] = 32'h0;
      end else begin
         if (sram_re | sram_we) check_eq("sram_rw_excl", 64'(sram_re & sram_we), 64'd0);
         if (mem_if.resp_val & mem_if.resp_rdy) begin
            mon_e.typ  = mem_if.resp_type;
            mon_e.data = mem_if.resp_data;
            mon_e.cyc  = cyc;
            obs_q.push_back(mon_e);
            if (exp_q.size() == 0) begin
               check_eq("resp_unexpected", 64'(mem_if.resp_val), 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check_eq("resp_type", 64'(mem_if.resp_type), 64'(mon_e.typ));
               check_eq("resp_data", 64'(mem_if.resp_data), 64'(mon_e.data));
               if (chk_lat) check_eq("resp_latency", 64'(cyc - mon_e.cyc), 64'd1);
            end
         end
         if (mem_if.req_val & mem_if.req_rdy) begin
            mon_e.typ  = mem_if.req_type;
            mon_e.cyc  = cyc;
            mon_e.data = 32'h0;
            if (mem_if.req_type == 1'b0) mon_e.data = ref_mem[mem_if.req_addr];
            else
               for (int b = 0; b < 4; b++)
                  if (mem_if.req_byte_en[b])
                     ref_mem[mem_if.req_addr][8*b +: 8] = mem_if.req_data[8*b +: 8];
            exp_q.push_back(mon_e);
         end
      end
   end

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      #1;
      check_eq("rst_outs", 64'({mem_if.resp_val, mem_if.req_rdy, init_done, sram_re, sram_we,
                                mem_if_b.req_rdy, b_init_done, b_we, b_re}), 64'd0);
      repeat (cycles) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic check_clear();
      for (int i = 0; i < c_n; i++) begin
         @(negedge clk);
         check_eq("clr_wr", 64'({mem_if.req_rdy, init_done, sram_we, sram_be, sram_waddr, sram_wd}),
                  64'({1'b0, 1'b0, 1'b1, 4'hF, 3'(i), 32'h0}));
      end
      @(negedge clk);
      check_eq("clr_done", 64'({init_done, mem_if.req_rdy, sram_we}), 64'b110);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic typ, input logic [2:0] addr, input logic [3:0] be, input logic [31:0] dat);
      logic acc;
      acc = 1'b0;
      mem_if.req_type    = typ;
      mem_if.req_addr    = addr;
      mem_if.req_byte_en = be;
      mem_if.req_data    = dat;
      mem_if.req_val     = 1'b1;
      for (int k = 0; k < 64 && !acc; k++) begin
         @(negedge clk);
         acc = mem_if.req_val & mem_if.req_rdy;
         @(posedge clk);
         #1;
         if (rand_mode) mem_if.resp_rdy = ($urandom_range(0, 3) != 0);
      end
      mem_if.req_val = 1'b0;
      if (!acc) check_eq("send_timeout", 64'(acc), 64'd1);
   endtask

   task automatic drain();
      mem_if.resp_rdy = 1'b1;
      for (int k = 0; k < 32 && exp_q.size() != 0; k++) begin
         @(posedge clk);
         #1;
      end
      check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   n0;
      int   bp_acc;
      int   stale;
      logic fire_now;

      rst_n = 1'b1;
      rand_mode = 1'b0;
      chk_lat   = 1'b0;
      mem_if.req_val = 1'b0;   mem_if.req_type = 1'b0;    mem_if.req_addr = 3'd0;
      mem_if.req_byte_en = 4'h0; mem_if.req_data = 32'h0; mem_if.resp_rdy = 1'b1;
      mem_if_b.req_val = 1'b0; mem_if_b.req_type = 1'b0;  mem_if_b.req_addr = 3'd0;
      mem_if_b.req_byte_en = 4'h0; mem_if_b.req_data = 32'h0; mem_if_b.resp_rdy = 1'b1;
      #2;
      do_reset(3);
      #1;
      check_eq("nc_init_done", 64'(b_init_done), 64'd1);
      check_eq("nc_req_rdy", 64'(mem_if_b.req_rdy), 64'd1);
      check_clear();

      // cleared word reads back as zero
      send(1'b0, 3'd5, 4'hF, 32'h0);
      drain();
      check_eq("clr_rd5", 64'({obs_q[$].typ, obs_q[$].data}), 64'd0);

      // partial byte-enable write then read
      send(1'b1, 3'd3, 4'b0011, 32'hDEADBEEF);
      send(1'b0, 3'd3, 4'hF, 32'h0);
      drain();
      n0 = obs_q.size();
      check_eq("bew_wr", 64'({obs_q[n0-2].typ, obs_q[n0-2].data}), 64'({1'b1, 32'h0}));
      check_eq("bew_rd", 64'({obs_q[n0-1].typ, obs_q[n0-1].data}), 64'({1'b0, 32'h0000BEEF}));

      // back-to-back write/read with resp_rdy high
      chk_lat = 1'b1;
      n0 = obs_q.size();
      for (int i = 0; i < 4; i++) begin
         send(1'b1, 3'(i), 4'hF, 32'hC0DE_0000 | 32'(i * 17));
         send(1'b0, 3'(i), 4'hF, 32'h0);
      end
      drain();
      chk_lat = 1'b0;
      check_eq("b2b_count", 64'(obs_q.size() - n0), 64'd8);

      // backpressure: exactly two accepts while resp_rdy is low
      n0 = obs_q.size();
      mem_if.resp_rdy = 1'b0;
      mem_if.req_type = 1'b0;
      mem_if.req_addr = 3'd0;
      mem_if.req_val  = 1'b1;
      bp_acc = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         fire_now = mem_if.req_val & mem_if.req_rdy;
         @(posedge clk);
         #1;
         if (fire_now) begin
            bp_acc++;
            mem_if.req_addr = 3'(bp_acc);
         end
      end
      check_eq("bp_accepts", 64'(bp_acc), 64'd2);
      check_eq("bp_hold", 64'({mem_if.req_rdy, mem_if.resp_val}), 64'b01);
      mem_if.req_val  = 1'b0;
      mem_if.resp_rdy = 1'b1;
      for (int i = 0; i < 6; i++) send(1'b0, 3'(i + 2), 4'hF, 32'h0);
      drain();
      check_eq("bp_no_loss", 64'(obs_q.size() - n0), 64'd8);

      // random traffic with random response stalls
      rand_mode = 1'b1;
      for (int i = 0; i < 150; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
            mem_if.resp_rdy = ($urandom_range(0, 3) != 0);
         end
         send(1'($urandom_range(0, 1)), 3'($urandom_range(0, c_n - 1)),
              4'($urandom_range(0, 15)), $urandom);
      end
      rand_mode = 1'b0;
      drain();

      // reset in the middle of the clear
      do_reset(2);
      for (int i = 0; i < 5; i++) @(negedge clk);
      check_eq("mid_clr_addr", 64'(sram_waddr), 64'd4);
      do_reset(2);
      check_clear();

      // reset with two responses queued
      mem_if.resp_rdy = 1'b0;
      send(1'b0, 3'd1, 4'hF, 32'h0);
      send(1'b0, 3'd2, 4'hF, 32'h0);
      @(posedge clk);
      #1;
      check_eq("q2_state", 64'({mem_if.resp_val, mem_if.req_rdy}), 64'b10);
      do_reset(2);
      check_clear();
      mem_if.resp_rdy = 1'b1;
      stale = 0;
      repeat (10) begin
         @(negedge clk);
         if (mem_if.resp_val) stale++;
      end
      check_eq("no_stale", 64'(stale), 64'd0);

      check_eq("nc_no_sram", 64'(b_en_cnt), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
